// File: rtl/wb_arb_pkg.sv
// Shared defaults, FSM state type and sweep limit for the writeback arbiter.
package wb_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W_DEF-1:0] LAST_ADDR = '1;

endpackage

// File: rtl/wb_arbiter_if.sv
// Requester, clear-control and register-file write signals of the writeback arbiter.
interface wb_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              clr_start;
  logic              clr_busy;
  logic              rg_wrt_en;
  logic [ADDR_W-1:0] rg_wrt_addr;
  logic [DATA_W-1:0] rg_wrt_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clr_start,
    input  req0_ready, req1_ready, clr_busy,
    input  rg_wrt_en, rg_wrt_addr, rg_wrt_data
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clr_start,
    output req0_ready, req1_ready, clr_busy,
    output rg_wrt_en, rg_wrt_addr, rg_wrt_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer updated only on a grant.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  // last_one = 1 means requester 1 was granted most recently
  logic last_one;

  always_comb begin
    grant0 = enable && valid0 && (!valid1 || last_one);
    grant1 = enable && valid1 && (!valid0 || !last_one);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_one <= 1'b1;
    end else if (grant0) begin
      last_one <= 1'b0;
    end else if (grant1) begin
      last_one <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin register-file writes plus a clear sweep of addresses 1..max.
// Optional macro WB_ARB_X0_FILTER_EN: accepted transfers to address 0 produce no write.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic        clk,
  input logic        reset,
  wb_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] SWEEP_LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              arb_en;
  logic              xfer;
  logic              wr_ok;
  logic [ADDR_W-1:0] xaddr;
  logic [DATA_W-1:0] xdata;

  assign arb_en = (state == ARB) && !bus.clr_start;

  rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .enable (arb_en),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .grant0 (bus.req0_ready),
    .grant1 (bus.req1_ready)
  );

  always_comb begin
    xfer  = bus.req0_ready || bus.req1_ready;
    xaddr = bus.req0_ready ? bus.req0_addr : bus.req1_addr;
    xdata = bus.req0_ready ? bus.req0_data : bus.req1_data;
  end

`ifdef WB_ARB_X0_FILTER_EN
  assign wr_ok = xfer && (xaddr != '0);
`else
  assign wr_ok = xfer;
`endif

  assign bus.clr_busy = (state == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ARB;
      cnt             <= '0;
      bus.rg_wrt_en   <= 1'b0;
      bus.rg_wrt_addr <= '0;
      bus.rg_wrt_data <= '0;
    end else begin
      case (state)
        ARB: begin
          if (bus.clr_start) begin
            state         <= CLEAR;
            cnt           <= ADDR_W'(1);
            bus.rg_wrt_en <= 1'b0;
          end else begin
            bus.rg_wrt_en <= wr_ok;
            if (wr_ok) begin
              bus.rg_wrt_addr <= xaddr;
              bus.rg_wrt_data <= xdata;
            end
          end
        end
        CLEAR: begin
          bus.rg_wrt_en   <= 1'b1;
          bus.rg_wrt_addr <= cnt;
          bus.rg_wrt_data <= '0;
          // counter saturates at the last address; the FSM leaves CLEAR instead
          if (cnt == SWEEP_LAST) begin
            state <= ARB;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_wb_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int LAST = (1 << AW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model: sweeping flag, next sweep address, last winner, output register
  bit        m_sweep;
  int        m_next;
  int        m_last;
  bit        m_en;
  int        m_addr;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // winner under the arbitration rules: -1 none, else requester index
  function automatic int winner(input bit v0, input bit v1, input bit clr);
    if (m_sweep || clr) return -1;
    if (v0 && v1) return (m_last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_sweep = 0; m_next = 0; m_last = 1; m_en = 0; m_addr = 0; m_data = '0;
  endtask

  task automatic check_outputs();
    check("rg_wrt_en", {31'd0, bus.rg_wrt_en}, {31'd0, m_en});
    check("rg_wrt_addr", {27'd0, bus.rg_wrt_addr}, m_addr);
    check("rg_wrt_data", bus.rg_wrt_data, m_data);
    check("clr_busy", {31'd0, bus.clr_busy}, {31'd0, m_sweep});
  endtask

  task automatic drive(input bit v0, input int a0, input logic [31:0] d0,
                       input bit v1, input int a1, input logic [31:0] d1, input bit clr);
    bus.req0_valid = v0; bus.req0_addr = AW'(a0); bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = AW'(a1); bus.req1_data = d1;
    bus.clr_start  = clr;
  endtask

  task automatic step(input bit v0, input int a0, input logic [31:0] d0,
                      input bit v1, input int a1, input logic [31:0] d1, input bit clr);
    int w;
    @(negedge clk);
    drive(v0, a0, d0, v1, a1, d1, clr);
    #1;
    w = winner(v0, v1, clr);
    check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, w == 0});
    check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, w == 1});
    @(posedge clk);
    if (m_sweep) begin
      m_en = 1; m_addr = m_next; m_data = '0;
      if (m_next == LAST) m_sweep = 0;
      else m_next++;
    end else if (clr) begin
      m_sweep = 1; m_next = 1; m_en = 0;
    end else if (w >= 0) begin
      m_last = w;
      m_en = 1;
`ifdef WB_ARB_X0_FILTER_EN
      if (((w == 0) ? a0 : a1) == 0) m_en = 0;
`endif
      if (m_en) begin
        m_addr = (w == 0) ? a0 : a1;
        m_data = (w == 0) ? d0 : d1;
      end
    end else begin
      m_en = 0;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    int busy_cycles;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_en", {31'd0, bus.rg_wrt_en}, 32'd0);
    check("reset_addr", {27'd0, bus.rg_wrt_addr}, 32'd0);
    check("reset_data", bus.rg_wrt_data, 32'd0);
    check("reset_busy", {31'd0, bus.clr_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // single requester, same-cycle grant, one-cycle write latency
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    check("d035_addr", {27'd0, bus.rg_wrt_addr}, 32'd5);
    check("d035_data", bus.rg_wrt_data, 32'hDEADBEEF);
    idle();
    check("d035_en_drop", {31'd0, bus.rg_wrt_en}, 32'd0);
    check("d035_hold", {27'd0, bus.rg_wrt_addr}, 32'd5);

    // round-robin alternation from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 2, 32'h200 + i, 1, 3, 32'h300 + i, 0);
      check("d036_addr", {27'd0, bus.rg_wrt_addr}, (i % 2 == 0) ? 32'd2 : 32'd3);
    end

    // full clear sweep with both requesters pending
    do_reset();
    step(1, 2, 32'hA, 1, 3, 32'hB, 1);
    busy_cycles = 0;
    for (int k = 1; k <= LAST; k++) begin
      if (bus.clr_busy) busy_cycles++;
      step(1, 2, 32'hA, 1, 3, 32'hB, 0);
      check("d037_sweep_addr", {27'd0, bus.rg_wrt_addr}, k);
    end
    check("d037_busy_cycles", busy_cycles, LAST);
    step(1, 2, 32'hA, 1, 3, 32'hB, 0);
    check("d037_first_after", {27'd0, bus.rg_wrt_addr}, 32'd2);

    // asynchronous reset mid-sweep
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 10; k++) step(0, 0, 0, 0, 0, 0, 0);
    check("d038_at10", {27'd0, bus.rg_wrt_addr}, 32'd10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("d038_en", {31'd0, bus.rg_wrt_en}, 32'd0);
    check("d038_busy", {31'd0, bus.clr_busy}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) idle();

    // address-0 transfer from requester 1
    step(0, 0, 0, 1, 0, 32'h1234, 0);
`ifdef WB_ARB_X0_FILTER_EN
    check("d039_en", {31'd0, bus.rg_wrt_en}, 32'd0);
`else
    check("d039_en", {31'd0, bus.rg_wrt_en}, 32'd1);
    check("d039_data", bus.rg_wrt_data, 32'h1234);
`endif
    check("d039_addr", {27'd0, bus.rg_wrt_addr}, 32'd0);

    // clr_start during a sweep is ignored
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= LAST; k++) begin
      step(1, 7, 32'h7, 0, 0, 0, (k == 21));
      check("d040_addr", {27'd0, bus.rg_wrt_addr}, k);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    check("d040_done_busy", {31'd0, bus.clr_busy}, 32'd0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, LAST), $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, LAST), $urandom,
           $urandom_range(0, 59) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the register address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 req0_valid/req1_valid  input  1  SHALL indicate a pending writeback from requester 0/1.
REQ-006 req0_addr/req1_addr  input  ADDR_W  SHALL give the destination register.
REQ-007 req0_data/req1_data  input  DATA_W  SHALL give the write data.
REQ-008 req0_ready/req1_ready  output  1  SHALL be the combinational grant; a transfer occurs when valid and ready are both high.
REQ-009 clr_start  input  1  SHALL request a sweep that clears the register file.
REQ-010 clr_busy  output  1  SHALL be high while the clear sweep runs.
REQ-011 rg_wrt_en  output  1  SHALL be the registered write enable to the register file.
REQ-012 rg_wrt_addr  output  ADDR_W  SHALL be the registered write address.
REQ-013 rg_wrt_data  output  DATA_W  SHALL be the registered write data.

Function
REQ-014 The FSM SHALL have exactly two states, ARB and CLEAR.
REQ-015 In ARB with one valid requester, that requester SHALL be granted in the same cycle.
REQ-016 In ARB with both requesters valid, the requester not granted most recently SHALL be granted (round-robin).
REQ-017 The last-grant pointer SHALL update only on a completed transfer.
REQ-018 At most one ready SHALL be high per cycle; ready SHALL never be high without the matching valid.
REQ-019 A granted transfer SHALL appear on rg_wrt_* exactly 1 cycle later, with rg_wrt_en=1 for exactly one cycle.
REQ-020 In a cycle with no transfer and no clear write, the next-cycle rg_wrt_en SHALL be 0.
REQ-021 When rg_wrt_en=0, rg_wrt_addr and rg_wrt_data SHALL hold their previous values.
REQ-022 clr_start in ARB SHALL take priority over requests: both readies 0 that cycle, next state CLEAR, and the sweep counter loaded with 1.
REQ-023 In CLEAR, the block SHALL write 0 to the counter address each cycle, so that output addresses 1..(2^ADDR_W-1) appear on consecutive cycles.
REQ-024 In CLEAR, both readies SHALL be 0, and the counter SHALL increment without wrapping past its maximum.
REQ-025 After the cycle that issues the maximum address, the FSM SHALL return to ARB; clr_busy SHALL be high exactly for the CLEAR cycles.
REQ-026 clr_start asserted while in CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-027 Address 0 SHALL never be written by the sweep.

Reset
REQ-028 Reset SHALL force state ARB, rg_wrt_en=0, rg_wrt_addr=0, rg_wrt_data=0, clr_busy=0, and counter=0.
REQ-029 Reset SHALL set the last-grant pointer to requester 1, so requester 0 wins the first tie.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep immediately; no write SHALL be issued after reset deasserts until a new grant or clr_start.

Configuration
REQ-031 With WB_ARB_X0_FILTER_EN defined, a granted transfer to address 0 SHALL be accepted (ready=1, pointer updated) but SHALL produce rg_wrt_en=0.
REQ-032 With WB_ARB_X0_FILTER_EN undefined, a transfer to address 0 SHALL be passed through like any other address.

Structure
REQ-033 Package wb_arb_pkg SHALL hold the ADDR_W/DATA_W defaults, the state enum {ARB, CLEAR}, and the constant LAST_ADDR = 2^ADDR_W-1.
REQ-034 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant and pointer; the FSM, counter and output register SHALL stay in wb_arbiter.

Verification
REQ-035 Directed: req0 valid, addr 5, data 0xDEADBEEF, req1 idle -> req0_ready=1 the same cycle; next cycle en=1, addr=5, data=0xDEADBEEF.
REQ-036 Directed: both valid for 4 cycles after reset (req0 addr 2, req1 addr 3) -> grants alternate 0,1,0,1; output addresses 2,3,2,3 each one cycle later.
REQ-037 Directed: clr_start with both requesters valid -> readies 0 for 32 cycles; writes of 0 to addresses 1..31 on consecutive cycles; clr_busy high for 31 cycles; req0 granted first afterward.
REQ-038 Directed: reset pulse at sweep address 10 -> en=0 and clr_busy=0 immediately; no further sweep writes.
REQ-039 Directed: req1 valid, addr 0, data 0x1234 -> with WB_ARB_X0_FILTER_EN: ready=1 and en stays 0; without the macro: en=1, addr=0.
REQ-040 Directed: clr_start pulsed at sweep address 20 -> the sweep continues to address 31 without restarting.
